// File: rtl/clk_div_multi.sv
// clk_div_multi: NCH independent registered clock dividers with shadowed, boundary-applied configuration.
// Ports: clk, rst_n (async active-low); cfg_wr/cfg_ch/cfg_div/cfg_en write a channel shadow, cfg_ack pulses
// one cycle later; clk_out/tick/pend are per-channel outputs. Define CLKDIV_SYNC_EN to add the sync input,
// which restarts every channel at cnt=0 and applies all pending shadows on the same edge.
module clk_div_multi #(
  parameter int NCH = 4,
  parameter int DIV_W = 26,
  parameter int DIV_RST = 1024,
  parameter logic [NCH-1:0] EN_RST = '1,
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_wr,
  input  logic [CW-1:0]    cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_en,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync,
`endif
  output logic             cfg_ack,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   pend
);
  logic run;
  logic rs;
`ifdef CLKDIV_SYNC_EN
  assign rs = sync;
`else
  assign rs = 1'b0;
`endif
  // run holds every counter at 0 on the first edge after reset release
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      run <= 1'b0;
      cfg_ack <= 1'b0;
    end else begin
      run <= 1'b1;
      cfg_ack <= cfg_wr;
    end
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [DIV_W-1:0] cnt, d, sd, deff, dn, deffn, cntn;
    logic e, se, p, bnd, xf, en, hit, co, tk;
    assign deff = d < DIV_W'(2) ? DIV_W'(2) : d;
    assign bnd = e && cnt == deff - 1'b1;
    // shadow moves to active only between periods, so no period is ever cut short or stretched
    assign xf = p && (bnd || !e || rs);
    assign dn = xf ? sd : d;
    assign en = xf ? se : e;
    assign deffn = dn < DIV_W'(2) ? DIV_W'(2) : dn;
    assign cntn = (!e || bnd || !run || rs) ? '0 : cnt + 1'b1;
    assign hit = cfg_wr && cfg_ch == CW'(i);
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        cnt <= '0;
        d <= DIV_W'(DIV_RST);
        e <= EN_RST[i];
        sd <= DIV_W'(DIV_RST);
        se <= EN_RST[i];
        p <= 1'b0;
        co <= 1'b0;
        tk <= 1'b0;
      end else begin
        cnt <= cntn;
        d <= dn;
        e <= en;
        sd <= hit ? cfg_div : sd;
        se <= hit ? cfg_en : se;
        p <= hit || (p && !xf);
        // outputs are decoded from next-state so they line up with the registered count
        co <= en && cntn < (deffn >> 1) + DIV_W'(deffn[0]);
        tk <= en && cntn == '0;
      end
    assign clk_out[i] = co;
    assign tick[i] = tk;
    assign pend[i] = p;
  end
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed and random stimulus for clk_div_multi checked against a per-channel period model.
module tb_clk_div_multi;
  logic clk = 0, rst_n = 0, cfg_wr = 0, cfg_en = 0, cfg_ack;
  logic [1:0] cfg_ch = 0;
  logic [25:0] cfg_div = 0;
  logic [3:0] clk_out, tick, pend;
`ifdef CLKDIV_SYNC_EN
  logic sync = 0;
`endif
  int n_cmp = 0, n_bad = 0;
  int per[4], sper[4], pos[4];
  bit en[4], sen[4], pnd[4], started, ack;
  clk_div_multi dut (
    .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_en(cfg_en),
`ifdef CLKDIV_SYNC_EN
    .sync(sync),
`endif
    .cfg_ack(cfg_ack), .clk_out(clk_out), .tick(tick), .pend(pend));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_init();
    for (int i = 0; i < 4; i++) begin
      per[i] = 1024; sper[i] = 1024; en[i] = 1; sen[i] = 1; pnd[i] = 0; pos[i] = 0;
    end
    started = 0; ack = 0;
  endtask
  // one clock of the reference: pos is the cycle index inside the current output period
  task automatic model(input bit wr, input int ch, input int dv, input bit e, input bit sy);
    int eff;
    bit bnd, xf;
    for (int i = 0; i < 4; i++) begin
      eff = per[i] < 2 ? 2 : per[i];
      bnd = en[i] && pos[i] == eff - 1;
      xf = pnd[i] && (bnd || !en[i] || sy);
      pos[i] = (!en[i] || bnd || !started || sy) ? 0 : pos[i] + 1;
      if (xf) begin per[i] = sper[i]; en[i] = sen[i]; end
      if (wr && ch == i) begin sper[i] = dv; sen[i] = e; pnd[i] = 1; end
      else if (xf) pnd[i] = 0;
    end
    started = 1; ack = wr;
  endtask
  task automatic step(input bit wr, input int ch, input int dv, input bit e, input bit sy);
    logic [3:0] eco, etk, epd;
    int eff;
    cfg_wr = wr; cfg_ch = 2'(ch); cfg_div = 26'(dv); cfg_en = e;
`ifdef CLKDIV_SYNC_EN
    sync = sy;
`endif
    @(posedge clk);
    model(wr, ch, dv, e, sy);
    #1;
    for (int i = 0; i < 4; i++) begin
      eff = per[i] < 2 ? 2 : per[i];
      eco[i] = en[i] && pos[i] < (eff + 1) / 2;
      etk[i] = en[i] && pos[i] == 0;
      epd[i] = pnd[i];
    end
    chk("clk_out", 32'(clk_out), 32'(eco));
    chk("tick", 32'(tick), 32'(etk));
    chk("pend", 32'(pend), 32'(epd));
    chk("cfg_ack", 32'(cfg_ack), 32'(ack));
    cfg_wr = 0;
`ifdef CLKDIV_SYNC_EN
    sync = 0;
`endif
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
  endtask
  task automatic do_reset();
    rst_n = 0; cfg_wr = 0;
    #1;
    chk("rst_clk_out", 32'(clk_out), 0);
    chk("rst_pend", 32'(pend), 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("rst_clk_out", 32'(clk_out), 0);
      chk("rst_tick", 32'(tick), 0);
      chk("rst_pend", 32'(pend), 0);
      chk("rst_ack", 32'(cfg_ack), 0);
    end
    rst_n = 1;
    model_init();
  endtask
  initial begin
    bit sy;
    #2;
    do_reset();
    idle(100);
    step(1, 1, 5, 1, 0);
    idle(1000);
    step(1, 2, 0, 1, 0);
    idle(1000);
    step(1, 2, 1, 1, 0);
    idle(20);
    step(1, 0, 3, 0, 0);
    idle(1100);
    step(1, 0, 3, 1, 0);
    idle(20);
    step(1, 3, 8, 1, 0);
    step(1, 3, 6, 1, 0);
    idle(1100);
`ifdef CLKDIV_SYNC_EN
    step(1, 0, 4, 1, 0);
    step(1, 1, 6, 1, 0);
    idle(3);
    step(0, 0, 0, 0, 1);
    idle(40);
`endif
    for (int k = 0; k < 600; k++) begin
      sy = 0;
`ifdef CLKDIV_SYNC_EN
      sy = $urandom_range(0, 29) == 0;
`endif
      if ($urandom_range(0, 3) == 0)
        step(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 9)), $urandom_range(0, 3) != 0, sy);
      else
        step(0, 0, 0, 0, sy);
    end
    step(1, 2, 7, 1, 0);
    step(1, 1, 4, 0, 0);
    do_reset();
    idle(1030);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
